// File: rtl/axis_slave_fifo.sv
// ---------------------------------------------------------------------------
// axis_slave_fifo
//
// AXI-Stream-style ingress slave for the resizer. Each accepted beat is packed
// into one entry of S_KEEP_WIDTH lanes. Each lane holds {data, last, keep}.
// The entries are buffered in a DEPTH-deep first-word-fall-through FIFO. Null
// beats (keep==0, last==0) can be consumed without being stored.
//
// Ports:
//   clk            in   single clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   s_valid_i      in   source beat valid
//   s_ready_o      out  slave ready (registered state only)
//   s_last_i       in   last beat of packet
//   s_keep_i       in   per-lane keep [S_KEEP_WIDTH]
//   s_data_i       in   lane data, unpacked [S_KEEP_WIDTH], lane 0 = LSB
//   en             in   ingress enable
//   entry_valid_o  out  FIFO head valid
//   entry_ready_i  in   consumer pops the head
//   entry_o        out  FIFO head entry (0 while empty)
//   level_o        out  current occupancy
//   drop_o         out  one-cycle pulse after a null beat is dropped
// ---------------------------------------------------------------------------
module axis_slave_fifo #(
    parameter int S_KEEP_WIDTH = 3,
    parameter int T_DATA_WIDTH = 8,
    parameter int DEPTH        = 4,
    parameter int DROP_NULL    = 1,
    localparam int LANE_SZ     = 2 + T_DATA_WIDTH,
    localparam int ENTRY_SZ    = LANE_SZ * S_KEEP_WIDTH,
    localparam int LVL_W       = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    input  logic                    s_last_i,
    input  logic [S_KEEP_WIDTH-1:0] s_keep_i,
    input  logic [T_DATA_WIDTH-1:0] s_data_i [S_KEEP_WIDTH],
    input  logic                    en,
    output logic                    entry_valid_o,
    input  logic                    entry_ready_i,
    output logic [ENTRY_SZ-1:0]     entry_o,
    output logic [LVL_W-1:0]        level_o,
    output logic                    drop_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ENTRY_SZ-1:0] mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [ENTRY_SZ-1:0] packed_beat;
    logic                accept;
    logic                is_null;
    logic                do_write;
    logic                do_pop;

    // Lane i = {data, last, keep}. Only the top lane carries the packet's last.
    always_comb begin
        // NOTE: default every combinational output first so no latch is inferred.
        packed_beat = '0;
        for (int i = 0; i < S_KEEP_WIDTH; i++) begin
            packed_beat[i*LANE_SZ]                     = s_keep_i[i];
            packed_beat[i*LANE_SZ+1]                   = (i == S_KEEP_WIDTH - 1) ? s_last_i : 1'b0;
            packed_beat[i*LANE_SZ+2 +: T_DATA_WIDTH]   = s_data_i[i];
        end
    end

    // Ready depends on registered level only: a pop in this cycle does not
    // open the input until the level has actually dropped.
    assign s_ready_o     = en && (level_o != LVL_W'(DEPTH));
    assign entry_valid_o = (level_o != '0);
    assign entry_o       = entry_valid_o ? mem[rd_ptr] : '0;

    // keep==0 with last==1 is never null: it still closes the packet.
    assign is_null  = (DROP_NULL != 0) && (s_keep_i == '0) && !s_last_i;
    assign accept   = s_valid_i && s_ready_o;
    assign do_write = accept && !is_null;
    assign do_pop   = entry_valid_o && entry_ready_i;

    // NOTE: storage carries no reset; the pointers and level define which
    // entries are meaningful, so clearing the array would only cost area.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= packed_beat;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_o <= '0;
            drop_o  <= 1'b0;
        end else begin
            drop_o <= accept && is_null;
            // DEPTH is a power of two, so pointer wrap is plain overflow.
            if (do_write) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({do_write, do_pop})
                2'b10:   level_o <= level_o + LVL_W'(1);
                2'b01:   level_o <= level_o - LVL_W'(1);
                default: level_o <= level_o;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_slave_fifo.sv
// ---------------------------------------------------------------------------
// tb_axis_slave_fifo
//
// Self-checking bench for axis_slave_fifo (3 lanes x 8 bits, DEPTH 4,
// DROP_NULL 1). A queue-based reference model predicts every output. Directed
// phases cover the corner cases. A random phase follows them.
// ---------------------------------------------------------------------------
module tb_axis_slave_fifo;

    localparam int KW    = 3;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int ESZ   = (DW + 2) * KW;
    localparam int LW    = $clog2(DEPTH + 1);

    logic           clk;
    logic           rst_n;
    logic           s_valid_i;
    logic           s_ready_o;
    logic           s_last_i;
    logic [KW-1:0]  s_keep_i;
    logic [DW-1:0]  s_data_i [KW];
    logic           en;
    logic           entry_valid_o;
    logic           entry_ready_i;
    logic [ESZ-1:0] entry_o;
    logic [LW-1:0]  level_o;
    logic           drop_o;

    axis_slave_fifo #(
        .S_KEEP_WIDTH (KW),
        .T_DATA_WIDTH (DW),
        .DEPTH        (DEPTH),
        .DROP_NULL    (1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_valid_i     (s_valid_i),
        .s_ready_o     (s_ready_o),
        .s_last_i      (s_last_i),
        .s_keep_i      (s_keep_i),
        .s_data_i      (s_data_i),
        .en            (en),
        .entry_valid_o (entry_valid_o),
        .entry_ready_i (entry_ready_i),
        .entry_o       (entry_o),
        .level_o       (level_o),
        .drop_o        (drop_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: FIFO contents as a queue plus the pending drop pulse.
    logic [ESZ-1:0] model_q [$];
    bit             drop_exp = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Lane i = {data[i], last (top lane only), keep[i]}, lanes concatenated LSB first.
    function automatic logic [ESZ-1:0] pack(input bit [KW-1:0] k, input bit l, input bit [KW*DW-1:0] d);
        logic [ESZ-1:0] e;
        e = '0;
        for (int i = 0; i < KW; i++) begin
            e[i*(DW+2)]            = k[i];
            e[i*(DW+2)+1]          = (i == KW - 1) ? l : 1'b0;
            e[i*(DW+2)+2 +: DW]    = d[i*DW +: DW];
        end
        return e;
    endfunction

    // One clock cycle: drive inputs, check outputs against the model, then
    // advance the model and the clock. Entered and left at posedge + 1.
    task automatic step(input bit v, input bit l, input bit [KW-1:0] k,
                        input bit [KW*DW-1:0] d, input bit e, input bit r);
        bit             exp_ready;
        bit             acc;
        bit             null_beat;
        logic [ESZ-1:0] exp_head;
        s_valid_i     = v;
        s_last_i      = l;
        s_keep_i      = k;
        for (int i = 0; i < KW; i++) s_data_i[i] = d[i*DW +: DW];
        en            = e;
        entry_ready_i = r;
        #1;
        exp_ready = e && (model_q.size() != DEPTH);
        exp_head  = (model_q.size() != 0) ? model_q[0] : '0;
        check("s_ready",     64'(s_ready_o),     64'(exp_ready));
        check("entry_valid", 64'(entry_valid_o), 64'(model_q.size() != 0));
        check("entry",       64'(entry_o),       64'(exp_head));
        check("level",       64'(level_o),       64'(model_q.size()));
        check("drop",        64'(drop_o),        64'(drop_exp));
        acc       = v && exp_ready;
        null_beat = acc && (k == '0) && !l;
        if ((model_q.size() != 0) && r) void'(model_q.pop_front());
        if (acc && !null_beat) model_q.push_back(pack(k, l, d));
        drop_exp = null_beat;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit r);
        step(1'b0, 1'b0, '0, '0, 1'b1, r);
    endtask

    initial begin
        rst_n         = 1'b0;
        s_valid_i     = 1'b0;
        s_last_i      = 1'b0;
        s_keep_i      = '0;
        en            = 1'b1;
        entry_ready_i = 1'b0;
        for (int i = 0; i < KW; i++) s_data_i[i] = '0;

        #3;
        check("rst_level", 64'(level_o),       64'd0);
        check("rst_valid", 64'(entry_valid_o), 64'd0);
        check("rst_entry", 64'(entry_o),       64'd0);
        check("rst_drop",  64'(drop_o),        64'd0);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Pack check: keep=111, last=1, lanes {A0,A1,A2}.
        step(1'b1, 1'b1, 3'b111, 24'hA2A1A0, 1'b1, 1'b1);
        check("pack_entry", 64'(entry_o), 64'h28BA1681);
        check("pack_level", 64'(level_o), 64'd1);
        idle(1'b1);
        check("pack_drained", 64'(level_o), 64'd0);

        // Fill / backpressure: six offered beats, only DEPTH accepted.
        for (int n = 0; n < 6; n++) step(1'b1, n[0], 3'b101, 24'(n * 24'h030201 + 24'h100000), 1'b1, 1'b0);
        check("full_level", 64'(level_o),   64'd4);
        check("full_ready", 64'(s_ready_o), 64'd0);
        for (int n = 0; n < 5; n++) idle(1'b1);

        // Null drop, then keep=0 with last=1 is stored.
        step(1'b1, 1'b0, 3'b000, 24'h5A5A5A, 1'b1, 1'b0);
        check("null_pulse", 64'(drop_o),  64'd1);
        check("null_level", 64'(level_o), 64'd0);
        step(1'b1, 1'b1, 3'b000, 24'h000000, 1'b1, 1'b0);
        check("null_pulse_end", 64'(drop_o), 64'd0);
        check("keep0_last",     64'(entry_o), 64'h200000);
        idle(1'b1);

        // Concurrency and wrap: level held at 1 while streaming 10 beats.
        step(1'b1, 1'b0, 3'b111, 24'h0C0B0A, 1'b1, 1'b0);
        for (int n = 0; n < 10; n++) step(1'b1, n[1], 3'b011, 24'($urandom), 1'b1, 1'b1);
        check("stream_level", 64'(level_o), 64'd1);
        idle(1'b1);

        // en gating: two stored entries drain while ingress is disabled.
        step(1'b1, 1'b0, 3'b001, 24'h111111, 1'b1, 1'b0);
        step(1'b1, 1'b1, 3'b100, 24'h222222, 1'b1, 1'b0);
        step(1'b1, 1'b0, 3'b111, 24'h333333, 1'b0, 1'b0);
        for (int n = 0; n < 3; n++) step(1'b1, 1'b0, 3'b111, 24'h444444, 1'b0, 1'b1);
        check("en_drained", 64'(level_o), 64'd0);

        // Asynchronous reset at level 3, between clock edges.
        for (int n = 0; n < 3; n++) step(1'b1, 1'b0, 3'b110, 24'(32'hABC000 + n), 1'b1, 1'b0);
        s_valid_i     = 1'b0;
        entry_ready_i = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(entry_valid_o), 64'd0);
        check("arst_level", 64'(level_o),       64'd0);
        check("arst_entry", 64'(entry_o),       64'd0);
        model_q.delete();
        drop_exp = 1'b0;
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 1'b1, 3'b010, 24'h00BEEF, 1'b1, 1'b0);
        check("post_rst_entry", 64'(entry_o), 64'(pack(3'b010, 1'b1, 24'h00BEEF)));
        idle(1'b1);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            bit [KW-1:0] k;
            k = ($urandom_range(0, 3) == 0) ? '0 : KW'($urandom);
            step(($urandom_range(0, 3) != 0), 1'($urandom), k, 24'($urandom),
                 ($urandom_range(0, 7) != 0), 1'($urandom));
        end
        for (int n = 0; n < DEPTH + 1; n++) idle(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axis_slave_fifo.md
Name: axis_slave_fifo

Overview:
- Parametrised AXI-Stream-style ingress slave for the resizer.
- Packs each accepted input beat into a per-lane entry of {data, last, keep}.
- Buffers entries in a DEPTH-deep first-word-fall-through FIFO with real backpressure on both sides.
- Can optionally drop null beats. Sits between the external stream source and the resizer core, which pops entries through a valid/ready handshake.

Parameters:
- S_KEEP_WIDTH, 3, number of byte/word lanes per input beat.
- T_DATA_WIDTH, 8, width of one lane's data.
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- DROP_NULL, 1, when 1, a beat with keep==0 and last==0 is accepted but not stored.
- LANE_SZ, 2+T_DATA_WIDTH, derived; bits per lane in an entry.
- ENTRY_SZ, LANE_SZ*S_KEEP_WIDTH, derived; entry width.
- LVL_W, $clog2(DEPTH+1), derived; width of the level output.

Ports:
- clk, input, 1, single clock; all state updates on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- s_valid_i, input, 1, source beat valid.
- s_ready_o, output, 1, slave ready.
- s_last_i, input, 1, last beat of packet.
- s_keep_i, input, S_KEEP_WIDTH, per-lane keep.
- s_data_i, input, T_DATA_WIDTH x [S_KEEP_WIDTH] unpacked array, lane data; lane 0 is the least significant.
- en, input, 1, ingress enable; when 0, no beats are accepted.
- entry_valid_o, output, 1, FIFO head valid.
- entry_ready_i, input, 1, consumer pops the head.
- entry_o, output, ENTRY_SZ, FIFO head entry.
- level_o, output, LVL_W, current occupancy.
- drop_o, output, 1, one-cycle pulse when a null beat is dropped.

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous assert, active low, and releases synchronously to clk.
  - On reset, read/write pointers = 0, level_o = 0, entry_valid_o = 0, drop_o = 0.
  - entry_o = 0 while empty. FIFO storage is not reset.
- Packing: lane i occupies entry bits [i*LANE_SZ +: LANE_SZ].
  - Bit 0 = s_keep_i[i].
  - Bit 1 = s_last_i for lane S_KEEP_WIDTH-1 only; 0 for all other lanes.
  - Bits [2 +: T_DATA_WIDTH] = s_data_i[i].
- s_ready_o = en && (level_o != DEPTH).
  - Registered-state only; there is no combinational path from entry_ready_i to s_ready_o.
  - A full FIFO popped this cycle still shows s_ready_o = 0 this cycle.
- Accept = s_valid_i && s_ready_o.
  - If DROP_NULL==1 and s_keep_i==0 and s_last_i==0: the beat is consumed, nothing is written, and drop_o = 1 next cycle.
  - keep==0 with last==1 is always stored, because it carries the end of packet.
  - Otherwise the packed beat is written at wr_ptr and wr_ptr increments modulo DEPTH.
- Read side is first-word-fall-through.
  - entry_valid_o = (level_o != 0).
  - entry_o = mem[rd_ptr] when valid, else 0.
  - Pop = entry_valid_o && entry_ready_i; rd_ptr increments modulo DEPTH.
- Latency: a beat accepted at edge N appears on entry_o and entry_valid_o after edge N. There is no same-cycle bypass.
- Level update, per cycle:
  - level_o += 1 on write only.
  - level_o -= 1 on pop only.
  - level_o is unchanged on simultaneous write and pop, or on neither.
- Boundaries:
  - Simultaneous write and pop at level 1: head advances to the new entry and entry_valid_o stays 1.
  - Pointer wrap at DEPTH-1 -> 0 is seamless.
  - en dropping mid-packet stops acceptance only; the read side keeps draining.
  - Source must hold beat fields stable while s_valid_i && !s_ready_o. This is a source obligation; the block does not check it.
- Reset mid-operation flushes all entries immediately, asynchronously. The consumer sees entry_valid_o fall without a pop.

Test Plan (S_KEEP_WIDTH=3, T_DATA_WIDTH=8, DEPTH=4, DROP_NULL=1):
- Pack check: one beat with keep=3'b111, last=1, data lanes {A0,A1,A2}, entry_ready_i=1 -> next cycle entry_valid_o=1, entry_o=30'h28BA1681, level_o=1, then 0 after the pop.
- Fill/backpressure: entry_ready_i=0, 6 consecutive valid beats -> 4 accepted, s_ready_o=0 with level_o=4. Release entry_ready_i -> entries pop in order and s_ready_o returns 1 the cycle after level_o drops to 3.
- Null drop: keep=0, last=0 beat -> s_ready_o=1, drop_o pulses 1 cycle, level_o unchanged. Then keep=0, last=1 -> stored with only bit 21 set (lane 2 last bit).
- Concurrency and wrap: stream 10 beats with entry_ready_i=1 at level 1 -> level_o stays 1 and the output sequence equals the input sequence across pointer wrap.
- en gating: drop en with 2 entries stored -> s_ready_o=0 immediately and both entries still drain.
- Reset: assert rst_n=0 asynchronously with level_o=3 -> entry_valid_o=0, level_o=0, entry_o=0 before the next clk edge. After release, the first beat lands correctly.
